buffer_t: RTL and testbench

- Transmit holding buffer for the UART TX path: a small synchronous FIFO between the CPU register interface and the TX serializer.
- CPU side writes bytes through a 2-bit register address; only the transmit-data address loads the FIFO.
- TX serializer side reads the head entry (first-word fall-through) and pops it with tRD.
- Status outputs tEMPTY and ttxrdy drive the serializer start logic and CPU status.

---
 rtl/buffer_t.sv | 173 +++++++++++++++++
 tb/tb_buffer_t.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_t.sv
// -----------------------------------------------------------------------------
// buffer_t -- UART transmit holding buffer
//
// Small synchronous FIFO between the CPU register interface and the TX
// serializer. The CPU writes bytes through a 2-bit register address; only
// the transmit-holding address (ADDR_THR) loads the FIFO. The serializer sees
// the head entry combinationally (first-word fall-through) and pops it with
// tRD.
//
// Parameters:
//   BITWIDTH  data width of each entry
//   DEPTH     number of entries (power of two, >= 2)
//   ADDR_THR  tpaddr value selecting the transmit-holding register
//
// Ports:
//   tClk      in   rising-edge clock
//   tRst      in   asynchronous active-high reset (clears pointers, count, storage)
//   tWR       in   CPU write strobe, level-sampled each rising edge
//   tpaddr    in   CPU register address; writes only accepted at ADDR_THR
//   tdataIn   in   CPU write data
//   tRD       in   serializer pop strobe, level-sampled each rising edge
//   tEMPTY    out  1 when the FIFO holds no entries
//   ttxrdy    out  1 when the FIFO is not full (CPU may write)
//   tdataOut  out  head entry, all-zero when empty
//   tOVR      out  sticky overrun flag (only with TXBUF_OVERRUN_EN)
//
// Build option:
//   `define TXBUF_OVERRUN_EN adds the tOVR port. tOVR is set on any edge where
//   a transmit-holding write is dropped because the FIFO is full and no pop
//   happens in the same cycle; only tRst clears it. Without the macro dropped
//   writes are silent and the port does not exist.
// -----------------------------------------------------------------------------
module buffer_t #(
  parameter int         BITWIDTH = 8,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] ADDR_THR = 2'b10
) (
  input  logic                tClk,
  input  logic                tRst,
  input  logic                tWR,
  input  logic [1:0]          tpaddr,
  input  logic [BITWIDTH-1:0] tdataIn,
  input  logic                tRD,
  output logic                tEMPTY,
  output logic                ttxrdy,
  output logic [BITWIDTH-1:0] tdataOut
`ifdef TXBUF_OVERRUN_EN
  ,
  output logic                tOVR
`endif
);

  // Pointer width indexes DEPTH entries; the count needs one extra bit so that
  // "full" (count == DEPTH) is distinguishable from "empty" (count == 0).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] countReg;
  logic [CW-1:0] countNext;
  logic [AW-1:0] wrPtrReg;
  logic [AW-1:0] wrPtrNext;
  logic [AW-1:0] rdPtrReg;
  logic [AW-1:0] rdPtrNext;

  // Storage flattened into a packed vector so the head can be selected with a
  // plain variable index while each entry keeps its own register block.
  logic [DEPTH-1:0][BITWIDTH-1:0] memFlat;

  // ---------------------------------------------------------------------------
  // Accept logic
  // ---------------------------------------------------------------------------
  logic isEmpty;
  logic isFull;
  logic addrHit;
  logic rdOk;
  logic wrOk;

  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == COUNT_FULL);
  assign addrHit = (tpaddr == ADDR_THR);

  // A pop needs something to pop. A write into a full FIFO is still accepted
  // when a pop frees the head slot on the same edge; because a pop requires a
  // non-empty FIFO, an empty FIFO with both strobes high performs only the
  // write.
  assign rdOk = tRD & ~isEmpty;
  assign wrOk = tWR & addrHit & (~isFull | rdOk);

  // Pointers wrap naturally because DEPTH is a power of two.
  assign wrPtrNext = wrOk ? (wrPtrReg + PTR_ONE) : wrPtrReg;
  assign rdPtrNext = rdOk ? (rdPtrReg + PTR_ONE) : rdPtrReg;

  always_comb begin
    countNext = countReg;
    case ({wrOk, rdOk})
      2'b10:   countNext = countReg + COUNT_ONE;
      2'b01:   countNext = countReg - COUNT_ONE;
      default: countNext = countReg;  // idle, or write+pop keeps occupancy
    endcase
  end

  always_ff @(posedge tClk or posedge tRst) begin
    if (tRst) begin
      countReg <= '0;
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      countReg <= countNext;
      wrPtrReg <= wrPtrNext;
      rdPtrReg <= rdPtrNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: one register per slot, cleared by reset so a stale byte can
  // never reach the serializer after a reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      localparam logic [AW-1:0] SLOT = AW'(gi);
      logic [BITWIDTH-1:0] entryReg;
      logic                entryWe;

      assign entryWe = wrOk & (wrPtrReg == SLOT);

      always_ff @(posedge tClk or posedge tRst) begin
        if (tRst) begin
          entryReg <= '0;
        end else if (entryWe) begin
          entryReg <= tdataIn;
        end
      end

      assign memFlat[gi] = entryReg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs: status comes from the registered count, so it reflects an
  // accepted operation one edge after it happens. The head is forced to zero
  // when empty rather than exposing whatever the read slot last held.
  // ---------------------------------------------------------------------------
  assign tEMPTY   = isEmpty;
  assign ttxrdy   = ~isFull;
  assign tdataOut = isEmpty ? '0 : memFlat[rdPtrReg];

`ifdef TXBUF_OVERRUN_EN
  // Sticky overrun: a transmit-holding write that finds the FIFO full with no
  // simultaneous pop is lost, and software must be able to see that later.
  logic ovrReg;
  logic ovrNext;

  assign ovrNext = ovrReg | (tWR & addrHit & isFull & ~rdOk);

  always_ff @(posedge tClk or posedge tRst) begin
    if (tRst) begin
      ovrReg <= 1'b0;
    end else begin
      ovrReg <= ovrNext;
    end
  end

  assign tOVR = ovrReg;
`endif

endmodule

// File: tb/tb_buffer_t.sv
// -----------------------------------------------------------------------------
// tb_buffer_t -- self-checking bench for buffer_t
//
// Scenario tasks drive the DUT and compare its outputs against a queue-based
// reference model of the transmit buffer. Define TXBUF_OVERRUN_EN for both
// bench and RTL to cover the tOVR flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buffer_t;

  localparam int DEPTH = 4;
  localparam logic [1:0] THR = 2'b10;

  logic       tClk;
  logic       tRst;
  logic       tWR;
  logic [1:0] tpaddr;
  logic [7:0] tdataIn;
  logic       tRD;
  logic       tEMPTY;
  logic       ttxrdy;
  logic [7:0] tdataOut;
`ifdef TXBUF_OVERRUN_EN
  logic       tOVR;
`endif

  buffer_t #(.BITWIDTH(8), .DEPTH(DEPTH), .ADDR_THR(THR)) dut (
    .tClk    (tClk),
    .tRst    (tRst),
    .tWR     (tWR),
    .tpaddr  (tpaddr),
    .tdataIn (tdataIn),
    .tRD     (tRD),
    .tEMPTY  (tEMPTY),
    .ttxrdy  (ttxrdy),
    .tdataOut(tdataOut)
`ifdef TXBUF_OVERRUN_EN
    ,
    .tOVR    (tOVR)
`endif
  );

  initial tClk = 1'b0;
  always #5 tClk = ~tClk;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: the FIFO contents as a plain queue plus the overrun flag.
  logic [7:0] modelQ[$];
  bit         modelOvr = 1'b0;

  function automatic logic [7:0] modelHead();
    if (modelQ.size() == 0) return 8'h00;
    return modelQ[0];
  endfunction

  task automatic modelReset();
    modelQ.delete();
    modelOvr = 1'b0;
  endtask

  // One clock transaction: apply strobes, let the edge happen, advance the
  // model by the buffer's rules, then sit 1ns past the edge for sampling.
  task automatic cycle(input bit wr, input logic [1:0] addr, input logic [7:0] data, input bit rd);
    bit wrAcc;
    bit rdAcc;
    tWR = wr; tpaddr = addr; tdataIn = data; tRD = rd;
    @(posedge tClk);
    rdAcc = rd && (modelQ.size() != 0);
    wrAcc = wr && (addr == THR) && ((modelQ.size() != DEPTH) || rdAcc);
    if (wr && (addr == THR) && (modelQ.size() == DEPTH) && !rdAcc) modelOvr = 1'b1;
    if (rdAcc) void'(modelQ.pop_front());
    if (wrAcc) modelQ.push_back(data);
    #1;
    tWR = 1'b0; tRD = 1'b0;
    $display("[%0t] wr=%0b addr=%0d din=%h rd=%0b -> wrOk=%0b rdOk=%0b count=%0d head=%h",
             $time, wr, addr, data, rd, wrAcc, rdAcc, modelQ.size(), tdataOut);
  endtask

  task automatic test_reset();
    tRst = 1'b1; tWR = 1'b0; tRD = 1'b0; tpaddr = 2'b00; tdataIn = 8'hAA;
    modelReset();
    #10;
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL reset_empty: got %b want 1", tEMPTY); end
    nCompared++;
    if (ttxrdy !== 1'b1) begin nMismatched++; $display("FAIL reset_txrdy: got %b want 1", ttxrdy); end
    nCompared++;
    if (tdataOut !== 8'h00) begin nMismatched++; $display("FAIL reset_data: got %h want 00", tdataOut); end
`ifdef TXBUF_OVERRUN_EN
    nCompared++;
    if (tOVR !== 1'b0) begin nMismatched++; $display("FAIL reset_ovr: got %b want 0", tOVR); end
`endif
    #2 tRst = 1'b0;
    @(posedge tClk); #1;
  endtask

  task automatic test_single_write();
    cycle(1'b1, 2'b00, 8'h5A, 1'b0);
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL wrong_addr_empty: got %b want 1", tEMPTY); end
    nCompared++;
    if (tdataOut !== 8'h00) begin nMismatched++; $display("FAIL wrong_addr_data: got %h want 00", tdataOut); end
    cycle(1'b1, THR, 8'hCC, 1'b0);
    nCompared++;
    if (tEMPTY !== 1'b0) begin nMismatched++; $display("FAIL single_write_empty: got %b want 0", tEMPTY); end
    nCompared++;
    if (ttxrdy !== 1'b1) begin nMismatched++; $display("FAIL single_write_txrdy: got %b want 1", ttxrdy); end
    nCompared++;
    if (tdataOut !== 8'hCC) begin nMismatched++; $display("FAIL single_write_data: got %h want cc", tdataOut); end
  endtask

  task automatic test_reset_dominance();
    // Assert reset away from any edge: it must take effect without a clock.
    tRst = 1'b1; tWR = 1'b1; tpaddr = THR; tdataIn = 8'hDD;
    modelReset();
    #1;
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL async_reset_empty: got %b want 1", tEMPTY); end
    nCompared++;
    if (tdataOut !== 8'h00) begin nMismatched++; $display("FAIL async_reset_data: got %h want 00", tdataOut); end
    #19;  // two rising edges pass with the write strobe held high
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL reset_dom_empty: got %b want 1", tEMPTY); end
    nCompared++;
    if (tdataOut !== 8'h00) begin nMismatched++; $display("FAIL reset_dom_data: got %h want 00", tdataOut); end
    tWR = 1'b0;
    #2 tRst = 1'b0;
    @(posedge tClk); #1;
    cycle(1'b0, THR, 8'h00, 1'b1);
    cycle(1'b0, THR, 8'h00, 1'b1);
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL underflow_empty: got %b want 1", tEMPTY); end
    nCompared++;
    if (ttxrdy !== 1'b1) begin nMismatched++; $display("FAIL underflow_txrdy: got %b want 1", ttxrdy); end
    // After the ignored pops a single write must show up as the only entry.
    cycle(1'b1, THR, 8'h12, 1'b0);
    nCompared++;
    if (tdataOut !== 8'h12) begin nMismatched++; $display("FAIL underflow_then_write: got %h want 12", tdataOut); end
    cycle(1'b0, THR, 8'h00, 1'b1);
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL underflow_drain: got %b want 1", tEMPTY); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) cycle(1'b1, THR, vals[i], 1'b0);
    nCompared++;
    if (ttxrdy !== 1'b0) begin nMismatched++; $display("FAIL fill_txrdy: got %b want 0", ttxrdy); end
`ifdef TXBUF_OVERRUN_EN
    nCompared++;
    if (tOVR !== 1'b0) begin nMismatched++; $display("FAIL fill_ovr_before: got %b want 0", tOVR); end
`endif
    cycle(1'b1, THR, 8'h55, 1'b0);
    nCompared++;
    if (tdataOut !== 8'h11) begin nMismatched++; $display("FAIL overflow_head: got %h want 11", tdataOut); end
`ifdef TXBUF_OVERRUN_EN
    nCompared++;
    if (tOVR !== 1'b1) begin nMismatched++; $display("FAIL overflow_ovr: got %b want 1", tOVR); end
`endif
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (tdataOut !== vals[i]) begin nMismatched++; $display("FAIL fill_pop_%0d: got %h want %h", i, tdataOut, vals[i]); end
      cycle(1'b0, THR, 8'h00, 1'b1);
    end
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL fill_drained: got %b want 1", tEMPTY); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    exp[0] = 8'hA3; exp[1] = 8'hB1; exp[2] = 8'hB2; exp[3] = 8'hB3;
    cycle(1'b1, THR, 8'hA1, 1'b0);
    cycle(1'b1, THR, 8'hA2, 1'b0);
    cycle(1'b1, THR, 8'hA3, 1'b0);
    nCompared++;
    if (tdataOut !== 8'hA1) begin nMismatched++; $display("FAIL wrap_pop0: got %h want a1", tdataOut); end
    cycle(1'b0, THR, 8'h00, 1'b1);
    nCompared++;
    if (tdataOut !== 8'hA2) begin nMismatched++; $display("FAIL wrap_pop1: got %h want a2", tdataOut); end
    cycle(1'b0, THR, 8'h00, 1'b1);
    cycle(1'b1, THR, 8'hB1, 1'b0);
    cycle(1'b1, THR, 8'hB2, 1'b0);
    cycle(1'b1, THR, 8'hB3, 1'b0);
    nCompared++;
    if (ttxrdy !== 1'b0) begin nMismatched++; $display("FAIL wrap_full: got %b want 0", ttxrdy); end
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (tdataOut !== exp[i]) begin nMismatched++; $display("FAIL wrap_order_%0d: got %h want %h", i, tdataOut, exp[i]); end
      cycle(1'b0, THR, 8'h00, 1'b1);
    end
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL wrap_drained: got %b want 1", tEMPTY); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [4];
    exp[0] = 8'hC2; exp[1] = 8'hC3; exp[2] = 8'hC4; exp[3] = 8'h66;
    cycle(1'b1, THR, 8'hC1, 1'b0);
    cycle(1'b1, THR, 8'hC2, 1'b0);
    cycle(1'b1, THR, 8'hC3, 1'b0);
    cycle(1'b1, THR, 8'hC4, 1'b0);
    cycle(1'b1, THR, 8'h66, 1'b1);
    nCompared++;
    if (ttxrdy !== 1'b0) begin nMismatched++; $display("FAIL simul_full_count: txrdy got %b want 0", ttxrdy); end
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (tdataOut !== exp[i]) begin nMismatched++; $display("FAIL simul_order_%0d: got %h want %h", i, tdataOut, exp[i]); end
      cycle(1'b0, THR, 8'h00, 1'b1);
    end
    cycle(1'b1, THR, 8'h77, 1'b1);
    nCompared++;
    if (tEMPTY !== 1'b0) begin nMismatched++; $display("FAIL simul_empty_write: empty got %b want 0", tEMPTY); end
    nCompared++;
    if (tdataOut !== 8'h77) begin nMismatched++; $display("FAIL simul_empty_data: got %h want 77", tdataOut); end
    cycle(1'b0, THR, 8'h00, 1'b1);
    nCompared++;
    if (tEMPTY !== 1'b1) begin nMismatched++; $display("FAIL simul_single_entry: empty got %b want 1", tEMPTY); end
  endtask

  task automatic test_random();
    bit         wr;
    bit         rd;
    logic [1:0] addr;
    logic [7:0] data;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        // Occasional asynchronous reset in the middle of traffic.
        tRst = 1'b1;
        modelReset();
        #2 tRst = 1'b0;
      end
      wr   = ($urandom_range(0, 99) < 60);
      rd   = ($urandom_range(0, 99) < 45);
      addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : THR;
      data = 8'($urandom);
      cycle(wr, addr, data, rd);
      nCompared++;
      if (tdataOut !== modelHead()) begin nMismatched++; $display("FAIL rand_data_%0d: got %h want %h", n, tdataOut, modelHead()); end
      nCompared++;
      if (tEMPTY !== (modelQ.size() == 0)) begin nMismatched++; $display("FAIL rand_empty_%0d: got %b want %b", n, tEMPTY, (modelQ.size() == 0)); end
      nCompared++;
      if (ttxrdy !== (modelQ.size() != DEPTH)) begin nMismatched++; $display("FAIL rand_txrdy_%0d: got %b want %b", n, ttxrdy, (modelQ.size() != DEPTH)); end
`ifdef TXBUF_OVERRUN_EN
      nCompared++;
      if (tOVR !== modelOvr) begin nMismatched++; $display("FAIL rand_ovr_%0d: got %b want %b", n, tOVR, modelOvr); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_reset_dominance();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
